axis_loopback_fifo: RTL and testbench

- Parametrised AXI4-Stream loopback for DMA bring-up. It sits between DMA MM2S (slave side) and DMA S2MM (master side).
- Adds a DEPTH-entry elastic FIFO, so s_axis_ready no longer depends combinationally on m_axis_ready.
- Carries TKEEP alongside data and last.
- Applies a per-packet data transform selected by a mode input, and exposes packet and occupancy status for software.

---
 rtl/axis_loopback_pkg.sv | 46 ++++
 rtl/axis_sync_fifo.sv | 70 +++++++
 rtl/axis_loopback_fifo.sv | 125 ++++++++++++
 tb/tb_axis_loopback_fifo.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_loopback_pkg.sv
// Shared types and helpers for the AXI4-Stream loopback FIFO.
// Mode encodings, latch states and width-generic byte-lane reversal.
package axis_loopback_pkg;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_BSWAP = 2'd1,
    MODE_INV   = 2'd2,
    MODE_INC   = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } lat_state_e;

  localparam int unsigned MAX_BYTES  = 128;
  localparam int unsigned MAX_DATA_W = MAX_BYTES * 8;

  // Reverse the lowest n_bytes byte lanes; callers cast to their real width.
  function automatic logic [MAX_DATA_W-1:0] byte_reverse(
    input logic [MAX_DATA_W-1:0] d,
    input int unsigned           n_bytes
  );
    logic [MAX_DATA_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      if (i < n_bytes) r[i*8 +: 8] = d[(n_bytes-1-i)*8 +: 8];
    end
    return r;
  endfunction

  // Same reversal applied to one enable bit per lane.
  function automatic logic [MAX_BYTES-1:0] lane_reverse(
    input logic [MAX_BYTES-1:0] k,
    input int unsigned          n_bytes
  );
    logic [MAX_BYTES-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      if (i < n_bytes) r[i] = k[n_bytes-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO with registered level and a registered not-full ready.
// Head entry reads as zero while empty so idle outputs stay quiet.
module axis_sync_fifo
  import axis_loopback_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_empty,
  output logic                     o_ready,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [LVL_W-1:0] r_level;
  logic             r_ready;
  logic [LVL_W-1:0] w_level_nxt;
  logic             w_empty;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_empty   = (r_level == '0);
  assign w_do_push = i_push & r_ready;
  assign w_do_pop  = i_pop & ~w_empty;

  always_comb begin
    w_level_nxt = r_level;
    case ({w_do_push, w_do_pop})
      2'b10:   w_level_nxt = r_level + LVL_W'(1);
      2'b01:   w_level_nxt = r_level - LVL_W'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // Ready is held low through reset and tracks not-full afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ready <= 1'b0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_do_pop)  r_rptr <= r_rptr + PTR_W'(1);
      r_level <= w_level_nxt;
      r_ready <= (w_level_nxt != LVL_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

  assign o_rdata = w_empty ? '0 : r_mem[r_rptr];
  assign o_empty = w_empty;
  assign o_ready = r_ready;
  assign o_level = r_level;

endmodule

// File: rtl/axis_loopback_fifo.sv
// AXI4-Stream loopback: per-packet mode latch and write-side transform in
// front of an elastic FIFO, with packet counters and occupancy for software.
module axis_loopback_fifo
  import axis_loopback_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                    axi_clk,
  input  logic                    axi_reset_n,
  input  logic                    s_axis_valid,
  input  logic [DATA_WIDTH-1:0]   s_axis_data,
  input  logic [KEEP_WIDTH-1:0]   s_axis_keep,
  input  logic                    s_axis_last,
  output logic                    s_axis_ready,
  output logic                    m_axis_valid,
  output logic [DATA_WIDTH-1:0]   m_axis_data,
  output logic [KEEP_WIDTH-1:0]   m_axis_keep,
  output logic                    m_axis_last,
  input  logic                    m_axis_ready,
  input  logic [1:0]              mode,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic [CNT_WIDTH-1:0]    pkt_in_count,
  output logic [CNT_WIDTH-1:0]    pkt_out_count
);

  localparam int unsigned ENTRY_W = DATA_WIDTH + KEEP_WIDTH + 1;

  lat_state_e            r_state;
  lat_state_e            w_state_nxt;
  mode_e                 r_cur_mode;
  mode_e                 w_cur_mode_nxt;
  mode_e                 w_eff_mode;
  logic [DATA_WIDTH-1:0] w_tx_data;
  logic [KEEP_WIDTH-1:0] w_tx_keep;
  logic                  w_fifo_ready;
  logic                  w_fifo_empty;
  logic [ENTRY_W-1:0]    w_head;
  logic                  w_push;
  logic                  w_pop;
  logic [CNT_WIDTH-1:0]  r_pkt_in;
  logic [CNT_WIDTH-1:0]  r_pkt_out;

  assign w_push = s_axis_valid & w_fifo_ready;
  assign w_pop  = m_axis_valid & m_axis_ready;

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      r_state    <= ST_IDLE;
      r_cur_mode <= MODE_PASS;
    end else begin
      r_state    <= w_state_nxt;
      r_cur_mode <= w_cur_mode_nxt;
    end
  end

  // First beat of a packet samples the mode input; later beats reuse it.
  always_comb begin
    w_state_nxt    = r_state;
    w_cur_mode_nxt = r_cur_mode;
    w_eff_mode     = (r_state == ST_PKT) ? r_cur_mode : mode_e'(mode);
    if (w_push) begin
      case (r_state)
        ST_IDLE: begin
          w_cur_mode_nxt = mode_e'(mode);
          if (!s_axis_last) w_state_nxt = ST_PKT;
        end
        ST_PKT: begin
          if (s_axis_last) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_tx_data = s_axis_data;
    w_tx_keep = s_axis_keep;
    case (w_eff_mode)
      MODE_BSWAP: begin
        w_tx_data = DATA_WIDTH'(byte_reverse(MAX_DATA_W'(s_axis_data), KEEP_WIDTH));
        w_tx_keep = KEEP_WIDTH'(lane_reverse(MAX_BYTES'(s_axis_keep), KEEP_WIDTH));
      end
      MODE_INV:  w_tx_data = ~s_axis_data;
      MODE_INC:  w_tx_data = s_axis_data + DATA_WIDTH'(1);
      default:   w_tx_data = s_axis_data;
    endcase
  end

  axis_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (axi_clk),
    .rst_n   (axi_reset_n),
    .i_push  (w_push),
    .i_wdata ({s_axis_last, w_tx_keep, w_tx_data}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_empty (w_fifo_empty),
    .o_ready (w_fifo_ready),
    .o_level (fifo_level)
  );

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      r_pkt_in  <= '0;
      r_pkt_out <= '0;
    end else begin
      if (w_push && s_axis_last)      r_pkt_in  <= r_pkt_in + CNT_WIDTH'(1);
      if (w_pop && m_axis_last)       r_pkt_out <= r_pkt_out + CNT_WIDTH'(1);
    end
  end

  assign s_axis_ready  = w_fifo_ready;
  assign m_axis_valid  = ~w_fifo_empty;
  assign m_axis_data   = w_head[DATA_WIDTH-1:0];
  assign m_axis_keep   = w_head[DATA_WIDTH +: KEEP_WIDTH];
  assign m_axis_last   = w_head[ENTRY_W-1];
  assign pkt_in_count  = r_pkt_in;
  assign pkt_out_count = r_pkt_out;

endmodule

// File: tb/tb_axis_loopback_fifo.sv
// Scoreboard bench for axis_loopback_fifo: a reference mode latch and
// transform predict each output beat at input accept time.
module tb_axis_loopback_fifo;

  logic        axi_clk;
  logic        axi_reset_n;
  logic        s_axis_valid;
  logic [31:0] s_axis_data;
  logic [3:0]  s_axis_keep;
  logic        s_axis_last;
  logic        s_axis_ready;
  logic        m_axis_valid;
  logic [31:0] m_axis_data;
  logic [3:0]  m_axis_keep;
  logic        m_axis_last;
  logic        m_axis_ready;
  logic [1:0]  mode;
  logic [4:0]  fifo_level;
  logic [15:0] pkt_in_count;
  logic [15:0] pkt_out_count;

  axis_loopback_fifo #(
    .DATA_WIDTH (32),
    .DEPTH      (16),
    .CNT_WIDTH  (16)
  ) dut (
    .axi_clk       (axi_clk),
    .axi_reset_n   (axi_reset_n),
    .s_axis_valid  (s_axis_valid),
    .s_axis_data   (s_axis_data),
    .s_axis_keep   (s_axis_keep),
    .s_axis_last   (s_axis_last),
    .s_axis_ready  (s_axis_ready),
    .m_axis_valid  (m_axis_valid),
    .m_axis_data   (m_axis_data),
    .m_axis_keep   (m_axis_keep),
    .m_axis_last   (m_axis_last),
    .m_axis_ready  (m_axis_ready),
    .mode          (mode),
    .fifo_level    (fifo_level),
    .pkt_in_count  (pkt_in_count),
    .pkt_out_count (pkt_out_count)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [36:0] exp_q [$];
  int          stamp_q [$];
  logic [31:0] out_log [$];
  logic [3:0]  last_out_keep;
  logic        chk_lat;
  logic        m_inpkt;
  logic [1:0]  m_cur;
  int          m_in_cnt;
  int          m_out_cnt;

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;
  always @(posedge axi_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [36:0] model_beat(input logic [31:0] d, input logic [3:0] k,
                                             input logic l, input logic [1:0] md);
    logic [31:0] rd;
    logic [3:0]  rk;
    rd = d;
    rk = k;
    case (md)
      2'd1: begin
        rd = {d[7:0], d[15:8], d[23:16], d[31:24]};
        rk = {k[0], k[1], k[2], k[3]};
      end
      2'd2:    rd = ~d;
      2'd3:    rd = d + 32'd1;
      default: rd = d;
    endcase
    return {l, rk, rd};
  endfunction

  // Handshakes observed mid-cycle describe the transfers of the next rising edge.
  always @(negedge axi_clk) begin
    logic [36:0] e;
    logic [1:0]  md;
    if (m_axis_valid && m_axis_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        chk("out_beat", 64'({m_axis_last, m_axis_keep, m_axis_data}), 64'(e));
        if (chk_lat) chk("latency", 64'(cyc - stamp_q[0]), 64'd1);
        void'(stamp_q.pop_front());
        if (e[36]) m_out_cnt++;
      end
      out_log.push_back(m_axis_data);
      last_out_keep = m_axis_keep;
    end
    if (s_axis_valid && s_axis_ready) begin
      md = m_inpkt ? m_cur : mode;
      if (!m_inpkt) m_cur = md;
      m_inpkt = !s_axis_last;
      exp_q.push_back(model_beat(s_axis_data, s_axis_keep, s_axis_last, md));
      stamp_q.push_back(cyc);
      if (s_axis_last) m_in_cnt++;
    end
  end

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k,
                           input logic l, input logic [1:0] md);
    int n;
    n = 0;
    s_axis_valid = 1'b1;
    s_axis_data  = d;
    s_axis_keep  = k;
    s_axis_last  = l;
    mode         = md;
    forever begin
      @(negedge axi_clk);
      if (s_axis_ready) break;
      n++;
      if (n > 2000) begin
        chk("send_timeout", 64'(n), 64'd0);
        break;
      end
    end
    @(posedge axi_clk);
    #1;
    s_axis_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_axis_valid) && n < 3000) begin
      @(negedge axi_clk);
      n++;
    end
    @(posedge axi_clk);
    #1;
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_in"},  64'(pkt_in_count),  64'(m_in_cnt));
    chk({tag, "_out"}, 64'(pkt_out_count), 64'(m_out_cnt));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    logic rnd_on;
    axi_reset_n  = 1'b0;
    s_axis_valid = 1'b0;
    s_axis_data  = '0;
    s_axis_keep  = '0;
    s_axis_last  = 1'b0;
    m_axis_ready = 1'b0;
    mode         = 2'd0;
    chk_lat      = 1'b0;
    m_inpkt      = 1'b0;
    m_cur        = 2'd0;
    m_in_cnt     = 0;
    m_out_cnt    = 0;
    last_out_keep = '0;

    // Reset values.
    #12;
    chk("rst_m_valid", 64'(m_axis_valid), 64'd0);
    chk("rst_s_ready", 64'(s_axis_ready), 64'd0);
    chk("rst_m_head",  64'({m_axis_last, m_axis_keep, m_axis_data}), 64'd0);
    chk("rst_level",   64'(fifo_level), 64'd0);
    chk("rst_pin",     64'(pkt_in_count), 64'd0);
    chk("rst_pout",    64'(pkt_out_count), 64'd0);
    @(negedge axi_clk);
    axi_reset_n = 1'b1;
    @(posedge axi_clk);
    #1;
    chk("post_rst_ready", 64'(s_axis_ready), 64'd1);

    // 4-beat pass-through packet, one cycle latency.
    m_axis_ready = 1'b1;
    chk_lat = 1'b1;
    send_beat(32'h11, 4'hF, 1'b0, 2'd0);
    send_beat(32'h22, 4'hF, 1'b0, 2'd0);
    send_beat(32'h33, 4'hF, 1'b0, 2'd0);
    send_beat(32'h44, 4'hF, 1'b1, 2'd0);
    wait_drain();
    chk_lat = 1'b0;
    chk("p1_pin",  64'(pkt_in_count), 64'd1);
    chk("p1_pout", 64'(pkt_out_count), 64'd1);

    // Fill to full with the sink stalled, then release.
    m_axis_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_beat(32'h100 + 32'(i), 4'hF, 1'b0, 2'd0);
    s_axis_valid = 1'b1;
    s_axis_data  = 32'h110;
    s_axis_keep  = 4'hF;
    s_axis_last  = 1'b1;
    @(negedge axi_clk);
    chk("full_ready", 64'(s_axis_ready), 64'd0);
    chk("full_level", 64'(fifo_level), 64'd16);
    @(posedge axi_clk);
    #1;
    m_axis_ready = 1'b1;
    @(negedge axi_clk);
    chk("full_pop_ready", 64'(s_axis_ready), 64'd0);
    chk("full_pop_level", 64'(fifo_level), 64'd16);
    @(negedge axi_clk);
    chk("after_pop_ready", 64'(s_axis_ready), 64'd1);
    chk("after_pop_level", 64'(fifo_level), 64'd15);
    @(posedge axi_clk);
    #1;
    s_axis_valid = 1'b0;
    wait_drain();
    chk_counts("p2");

    // Byte-lane reversal.
    send_beat(32'h11223344, 4'b0011, 1'b1, 2'd1);
    wait_drain();
    chk("bswap_data", 64'(out_log[out_log.size()-1]), 64'h44332211);
    chk("bswap_keep", 64'(last_out_keep), 64'hC);

    // Increment wrap, then mode held across a packet.
    send_beat(32'hFFFFFFFF, 4'hF, 1'b1, 2'd3);
    wait_drain();
    chk("inc_wrap", 64'(out_log[out_log.size()-1]), 64'd0);
    send_beat(32'd5, 4'hF, 1'b0, 2'd3);
    send_beat(32'd6, 4'hF, 1'b0, 2'd2);
    send_beat(32'd7, 4'hF, 1'b1, 2'd2);
    wait_drain();
    n0 = out_log.size();
    chk("hold_b0", 64'(out_log[n0-3]), 64'd6);
    chk("hold_b1", 64'(out_log[n0-2]), 64'd7);
    chk("hold_b2", 64'(out_log[n0-1]), 64'd8);
    chk_counts("p4");

    // Random traffic with random back-pressure.
    rnd_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 2)) @(posedge axi_clk);
          #1;
          send_beat($urandom, 4'($urandom_range(0, 15)),
                    (i == 999) || ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)));
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge axi_clk);
          #1;
          m_axis_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    m_axis_ready = 1'b1;
    wait_drain();
    chk_counts("rnd");

    // Reset with a partial packet buffered.
    m_axis_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_beat(32'hA0 + 32'(i), 4'hF, 1'b0, 2'd1);
    chk("pre_rst_level", 64'(fifo_level), 64'd5);
    axi_reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(m_axis_valid), 64'd0);
    chk("mid_rst_level", 64'(fifo_level), 64'd0);
    chk("mid_rst_pin",   64'(pkt_in_count), 64'd0);
    exp_q.delete();
    stamp_q.delete();
    m_inpkt   = 1'b0;
    m_in_cnt  = 0;
    m_out_cnt = 0;
    #10;
    axi_reset_n = 1'b1;
    @(posedge axi_clk);
    #1;
    m_axis_ready = 1'b1;
    n0 = out_log.size();
    send_beat(32'h0F0F0F0F, 4'hF, 1'b1, 2'd2);
    wait_drain();
    chk("post_rst_beats", 64'(out_log.size() - n0), 64'd1);
    chk("post_rst_data",  64'(out_log[out_log.size()-1]), 64'hF0F0F0F0);
    chk("post_rst_pin",   64'(pkt_in_count), 64'd1);
    chk("post_rst_pout",  64'(pkt_out_count), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
